// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART front-end blocks.
package uart_pkg;

  // Which accepted transitions drive pulse_out.
  typedef enum logic [1:0] {
    EDGE_RISE,
    EDGE_FALL,
    EDGE_BOTH
  } edge_mode_e;

  localparam int unsigned DEFAULT_SYNC_STAGES = 2;

  // Wide enough for the largest filter length (15).
  localparam int unsigned FILTER_CNT_W = 4;

endpackage

// File: rtl/bit_synchronizer.sv
// Generic flop-chain synchroniser for a single asynchronous bit.
module bit_synchronizer #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] s;

  // Shift the async level through the chain; only the last stage is read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      s <= {s[SYNC_STAGES-2:0], d};
    end
  end

  assign q = s[SYNC_STAGES-1];

endmodule

// File: rtl/edge_detector.sv
// Synchronises an async level, optionally glitch-filters it, and emits
// single-cycle pulses on accepted rising/falling transitions.
module edge_detector
  import uart_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int unsigned FILTER_LEN  = 0,
  parameter edge_mode_e  EDGE_MODE   = EDGE_BOTH,
  parameter logic        RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic data_in,
  output logic data_sync,
  output logic rise_out,
  output logic fall_out,
  output logic pulse_out
);

  logic raw;
  logic level;
  logic prev_q;
  logic rise_d;
  logic fall_d;
  logic pulse_d;

  bit_synchronizer #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_LEVEL (RESET_LEVEL)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (data_in),
    .q   (raw)
  );

  if (FILTER_LEN == 0) begin : g_no_filter
    assign level = raw;
  end else begin : g_filter
    logic [FILTER_CNT_W-1:0] cnt_q;
    logic                    level_q;

    // Adopt raw only after it has differed from level for FILTER_LEN cycles in a row.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q   <= '0;
        level_q <= RESET_LEVEL;
      end else if (raw == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == FILTER_CNT_W'(FILTER_LEN - 1)) begin
        level_q <= raw;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + FILTER_CNT_W'(1);
      end
    end

    assign level = level_q;
  end

  // Edge decode and mode selection feeding the output registers.
  always_comb begin
    rise_d  = level & ~prev_q;
    fall_d  = ~level & prev_q;
    pulse_d = rise_d | fall_d;
    case (EDGE_MODE)
      EDGE_RISE: pulse_d = rise_d;
      EDGE_FALL: pulse_d = fall_d;
      default:   pulse_d = rise_d | fall_d;
    endcase
  end

  // Registered edge stage; prev resets to RESET_LEVEL so reset release never pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q    <= RESET_LEVEL;
      rise_out  <= 1'b0;
      fall_out  <= 1'b0;
      pulse_out <= 1'b0;
    end else begin
      prev_q    <= level;
      rise_out  <= rise_d;
      fall_out  <= fall_d;
      pulse_out <= pulse_d;
    end
  end

  assign data_sync = level;

endmodule

// File: tb/tb_edge_detector.sv
// Directed bench for edge_detector: three instances share one input
// (both-edge unfiltered, fall-only unfiltered, both-edge with FILTER_LEN=4).
module tb_edge_detector;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic data_in = 1'b0;

  logic sync0, rise0, fall0, pulse0;
  logic sync1, rise1, fall1, pulse1;
  logic sync2, rise2, fall2, pulse2;

  int errors = 0;
  int checks = 0;

  always #10 clk = ~clk;

  edge_detector #(
    .SYNC_STAGES (2),
    .FILTER_LEN  (0),
    .EDGE_MODE   (EDGE_BOTH),
    .RESET_LEVEL (1'b0)
  ) u_both (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .data_sync (sync0),
    .rise_out  (rise0),
    .fall_out  (fall0),
    .pulse_out (pulse0)
  );

  edge_detector #(
    .SYNC_STAGES (2),
    .FILTER_LEN  (0),
    .EDGE_MODE   (EDGE_FALL),
    .RESET_LEVEL (1'b0)
  ) u_fall (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .data_sync (sync1),
    .rise_out  (rise1),
    .fall_out  (fall1),
    .pulse_out (pulse1)
  );

  edge_detector #(
    .SYNC_STAGES (2),
    .FILTER_LEN  (4),
    .EDGE_MODE   (EDGE_BOTH),
    .RESET_LEVEL (1'b0)
  ) u_filt (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .data_sync (sync2),
    .rise_out  (rise2),
    .fall_out  (fall2),
    .pulse_out (pulse2)
  );

  typedef struct {
    logic d;
    logic sync;
    logic rise;
    logic fall;
    logic pulse_both;
    logic pulse_fall;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_low(input string tag);
    check({tag, "_sync0"}, int'(sync0), 0);
    check({tag, "_rise0"}, int'(rise0), 0);
    check({tag, "_fall0"}, int'(fall0), 0);
    check({tag, "_pulse0"}, int'(pulse0), 0);
    check({tag, "_pulse1"}, int'(pulse1), 0);
  endtask

  // Raise data_in for 'hold' cycles and record the first cycle each instance
  // shows rise_out plus how many rise cycles appear.
  task automatic run_pulse(input int hold, output int first0, output int first2,
                           output int n0, output int n2);
    first0 = -1;
    first2 = -1;
    n0 = 0;
    n2 = 0;
    data_in = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (rise0) begin
        n0++;
        if (first0 < 0) first0 = i;
      end
      if (rise2) begin
        n2++;
        if (first2 < 0) first2 = i;
      end
      if (i == hold) data_in = 1'b0;
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int f0, f2, c0, c2;
    int trans, pulses, viol;
    logic prev_sync, prev_rise, prev_fall;

    //            d     sync  rise  fall  p_both p_fall
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset held 3 cycles with data_in low: everything stays quiet.
    rst = 1'b1;
    data_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_all_low("reset");
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_all_low("post_reset");
    end

    // Table: row r drives d at a falling edge, outputs checked one cycle later.
    for (int r = 0; r < 12; r++) begin
      data_in = vecs[r].d;
      @(negedge clk);
      check($sformatf("vec%0d_sync", r), int'(sync0), int'(vecs[r].sync));
      check($sformatf("vec%0d_rise", r), int'(rise0), int'(vecs[r].rise));
      check($sformatf("vec%0d_fall", r), int'(fall0), int'(vecs[r].fall));
      check($sformatf("vec%0d_pulse_both", r), int'(pulse0), int'(vecs[r].pulse_both));
      check($sformatf("vec%0d_rise_fmode", r), int'(rise1), int'(vecs[r].rise));
      check($sformatf("vec%0d_pulse_fall", r), int'(pulse1), int'(vecs[r].pulse_fall));
    end

    // Filter: a 2-cycle glitch is dropped, a 6-cycle level is accepted 4 cycles late.
    data_in = 1'b0;
    do_reset(2);
    run_pulse(2, f0, f2, c0, c2);
    check("glitch_unfilt_first", f0, 3);
    check("glitch_unfilt_count", c0, 1);
    check("glitch_filt_count", c2, 0);
    run_pulse(6, f0, f2, c0, c2);
    check("long_unfilt_first", f0, 3);
    check("long_filt_first", f2, 7);
    check("long_filt_count", c2, 1);

    // Random toggling: pulses must track data_sync transitions one for one.
    data_in = 1'b0;
    repeat (6) @(negedge clk);
    trans = 0;
    pulses = 0;
    viol = 0;
    prev_sync = sync0;
    prev_rise = rise0;
    prev_fall = fall0;
    fork
      begin
        for (int t = 0; t < 12; t++) begin
          #($urandom_range(40, 25));
          data_in = ~data_in;
        end
      end
      begin
        for (int i = 0; i < 34; i++) begin
          @(negedge clk);
          if (sync0 != prev_sync) trans++;
          if (pulse0) pulses++;
          if (rise0 && fall0) viol++;
          if (rise0 && prev_rise) viol++;
          if (fall0 && prev_fall) viol++;
          if (pulse0 != (rise0 | fall0)) viol++;
          prev_sync = sync0;
          prev_rise = rise0;
          prev_fall = fall0;
        end
      end
    join
    check("random_pulse_vs_trans", pulses, trans);
    check("random_violations", viol, 0);

    // Reset during a pulse clears outputs at once; high input yields one rise after release.
    data_in = 1'b0;
    do_reset(2);
    data_in = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_rst_rise", int'(rise0), 1);
    rst = 1'b1;
    #1;
    check("async_rst_pulse", int'(pulse0), 0);
    check("async_rst_rise", int'(rise0), 0);
    check("async_rst_sync", int'(sync0), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check($sformatf("release_rise_c%0d", i), int'(rise0), (i == 3) ? 1 : 0);
      check($sformatf("release_sync_c%0d", i), int'(sync0), (i >= 2) ? 1 : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
